any1_gpredictor: RTL and testbench

- Parametrised global-history branch direction predictor for the ANY-1 fetch/execute pipeline.
- Selects gselect or gshare indexing, table depth, history length and counter width.
- Keeps a speculative global history, with checkpoint restore on mispredict.
- Initialises its pattern table with a post-reset sweep, and updates counters through a bypassed read-modify-write pipeline.

---
 rtl/any1_gpredictor.sv | 120 ++++++++++++
 tb/tb_any1_gpredictor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/any1_gpredictor.sv
// Global-history branch direction predictor (gselect/gshare) with a post-reset
// table sweep, checkpointed speculative history and a bypassed 2-stage counter update.
module any1_gpredictor #(
    parameter int IP_LSB    = 3,
    parameter int TBL_BITS  = 9,
    parameter int HIST_BITS = 2,
    parameter int MODE      = 0,
    parameter int CTR_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 ready,
    input  logic [31:0]          ip,
    input  logic                 ip_valid,
    input  logic                 isBranch,
    output logic                 predict_valid,
    output logic                 predict_taken,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 xisBranch,
    input  logic [31:0]          xip,
    input  logic [HIST_BITS-1:0] xhist,
    input  logic                 takb,
    input  logic                 xmispredict
);
    localparam int DEPTH = 2 ** TBL_BITS;
    localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nxt;

    logic [CTR_BITS-1:0]  tbl [DEPTH];
    logic [TBL_BITS-1:0]  init_ptr, pidx, xidx, u2_idx;
    logic [CTR_BITS-1:0]  u2_ctr, u2_new, pred_ctr, u1_ctr;
    logic [HIST_BITS-1:0] ghist;
    logic                 u2_vld, u2_takb, pred_go, upd_go;

    function automatic logic [HIST_BITS-1:0] shl(input logic [HIST_BITS-1:0] h, input logic b);
        logic [HIST_BITS:0] t;
        t = {h, b};
        return t[HIST_BITS-1:0];
    endfunction

    generate
        if (MODE == 0) begin : g_sel
            assign pidx = {ip[IP_LSB+TBL_BITS-HIST_BITS-1:IP_LSB], ghist};
            assign xidx = {xip[IP_LSB+TBL_BITS-HIST_BITS-1:IP_LSB], xhist};
        end else begin : g_share
            assign pidx = ip[IP_LSB+TBL_BITS-1:IP_LSB] ^ TBL_BITS'(ghist);
            assign xidx = xip[IP_LSB+TBL_BITS-1:IP_LSB] ^ TBL_BITS'(xhist);
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = &{1'b0, ip, xip};

    assign ready   = (state == RUN);
    assign pred_go = ready & en & ip_valid;
    assign upd_go  = ready & en & xisBranch;

    always_comb begin
        u2_new = u2_ctr;
        if (u2_takb) begin
            if (u2_ctr != '1) u2_new = u2_ctr + CTR_BITS'(1);
        end else begin
            if (u2_ctr != '0) u2_new = u2_ctr - CTR_BITS'(1);
        end
    end

    // Both read ports see the in-flight U2 result so same-index traffic never reads stale.
    assign pred_ctr = (u2_vld && u2_idx == pidx) ? u2_new : tbl[pidx];
    assign u1_ctr   = (u2_vld && u2_idx == xidx) ? u2_new : tbl[xidx];

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_ptr == '1) state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (state == INIT)  tbl[init_ptr] <= WEAK;
        else if (u2_vld)    tbl[u2_idx]   <= u2_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= INIT;
            init_ptr      <= '0;
            ghist         <= '0;
            u2_vld        <= 1'b0;
            u2_idx        <= '0;
            u2_ctr        <= '0;
            u2_takb       <= 1'b0;
            predict_valid <= 1'b0;
            predict_taken <= 1'b0;
            pred_hist     <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) init_ptr <= init_ptr + TBL_BITS'(1);

            predict_valid <= pred_go;
            if (pred_go) begin
                predict_taken <= pred_ctr[CTR_BITS-1];
                pred_hist     <= ghist;
            end

            u2_vld <= upd_go;
            if (upd_go) begin
                u2_idx  <= xidx;
                u2_ctr  <= u1_ctr;
                u2_takb <= takb;
            end

            // Checkpoint restore takes priority over the speculative shift.
            if (upd_go && xmispredict)
                ghist <= shl(xhist, takb);
            else if (en && predict_valid && isBranch)
                ghist <= shl(ghist, predict_taken);
        end
    end
endmodule

// File: tb/tb_any1_gpredictor.sv
// Directed bench for any1_gpredictor: gselect instance driven by a vector table,
// plus a gshare instance sharing the same inputs for the XOR-index case.
module tb_any1_gpredictor;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [31:0] ip = '0, xip = '0;
    logic        ip_valid = 1'b0, isBranch = 1'b0, xisBranch = 1'b0, takb = 1'b0, xmispredict = 1'b0;
    logic [1:0]  xhist = '0;
    logic        ready0, pv0, pt0, ready1, pv1, pt1;
    logic [1:0]  ph0, ph1;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    any1_gpredictor #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .ready(ready0), .ip(ip), .ip_valid(ip_valid),
        .isBranch(isBranch), .predict_valid(pv0), .predict_taken(pt0), .pred_hist(ph0),
        .xisBranch(xisBranch), .xip(xip), .xhist(xhist), .takb(takb), .xmispredict(xmispredict));

    any1_gpredictor #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .ready(ready1), .ip(ip), .ip_valid(ip_valid),
        .isBranch(isBranch), .predict_valid(pv1), .predict_taken(pt1), .pred_hist(ph1),
        .xisBranch(xisBranch), .xip(xip), .xhist(xhist), .takb(takb), .xmispredict(xmispredict));

    typedef struct {
        logic en, ipv; logic [31:0] ip; logic isb, xb; logic [31:0] xip;
        logic [1:0] xh; logic tk, xm, epv, ept; logic [1:0] eph;
    } vec_t;

    function automatic vec_t mk(logic en_, logic ipv_, logic [31:0] ip_, logic isb_, logic xb_,
                                logic [31:0] xip_, logic [1:0] xh_, logic tk_, logic xm_,
                                logic epv_, logic ept_, logic [1:0] eph_);
        vec_t v;
        v.en = en_; v.ipv = ipv_; v.ip = ip_; v.isb = isb_; v.xb = xb_; v.xip = xip_;
        v.xh = xh_; v.tk = tk_; v.xm = xm_; v.epv = epv_; v.ept = ept_; v.eph = eph_;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        en = v.en; ip_valid = v.ipv; ip = v.ip; isBranch = v.isb; xisBranch = v.xb;
        xip = v.xip; xhist = v.xh; takb = v.tk; xmispredict = v.xm;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, 512);
        chk({name, "_gshare"}, ready1, 1);
    endtask

    vec_t vt[24];
    vec_t idle;

    initial begin
        #200_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        idle   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Test 2: counter at gselect index 0x80 walks 2->1->0->0->1->2
        vt[0]  = mk(1, 1, 'h100, 0, 0, 0,      0, 0, 0, 1, 1, 0);
        vt[1]  = mk(1, 0, 0,     0, 1, 'h100, 0, 0, 0, 0, 1, 0);
        vt[2]  = mk(1, 1, 'h100, 0, 0, 0,      0, 0, 0, 1, 0, 0);
        vt[3]  = mk(1, 0, 0,     0, 1, 'h100, 0, 0, 0, 0, 0, 0);
        vt[4]  = mk(1, 1, 'h100, 0, 1, 'h100, 0, 0, 0, 1, 0, 0);
        vt[5]  = mk(1, 1, 'h100, 0, 1, 'h100, 0, 1, 0, 1, 0, 0);
        vt[6]  = mk(1, 1, 'h100, 0, 1, 'h100, 0, 1, 0, 1, 0, 0);
        vt[7]  = mk(1, 1, 'h100, 0, 0, 0,      0, 0, 0, 1, 1, 0);
        vt[8]  = mk(1, 1, 'h100, 0, 0, 0,      0, 0, 0, 1, 1, 0);
        vt[9]  = mk(1, 0, 0,     0, 0, 0,      0, 0, 0, 0, 1, 0);
        // Tests 3/4: speculative shifts 00->01->11, then restore to 10 beats a shift
        vt[10] = mk(1, 1, 'h100, 0, 0, 0,      0, 0, 0, 1, 1, 0);
        vt[11] = mk(1, 1, 'h100, 1, 0, 0,      0, 0, 0, 1, 1, 0);
        vt[12] = mk(1, 1, 'h100, 1, 0, 0,      0, 0, 0, 1, 1, 1);
        vt[13] = mk(1, 1, 'h100, 0, 0, 0,      0, 0, 0, 1, 1, 3);
        vt[14] = mk(1, 0, 0,     1, 1, 'h300, 1, 0, 1, 0, 1, 3);
        vt[15] = mk(1, 1, 'h100, 0, 0, 0,      0, 0, 0, 1, 1, 2);
        vt[16] = mk(0, 1, 'h100, 1, 0, 0,      0, 0, 0, 0, 1, 2);
        vt[17] = mk(1, 1, 'h100, 0, 0, 0,      0, 0, 0, 1, 1, 2);
        // Test 6: back-to-back decrements 2->1->0 via bypass, then +1 -> 1 (not taken)
        vt[18] = mk(1, 0, 0,     0, 1, 'h200, 2, 0, 0, 0, 1, 2);
        vt[19] = mk(1, 0, 0,     0, 1, 'h200, 2, 0, 0, 0, 1, 2);
        vt[20] = mk(1, 0, 0,     0, 0, 0,      0, 0, 0, 0, 1, 2);
        vt[21] = mk(1, 0, 0,     0, 1, 'h200, 2, 1, 0, 0, 1, 2);
        vt[22] = mk(1, 0, 0,     0, 0, 0,      0, 0, 0, 0, 1, 2);
        vt[23] = mk(1, 1, 'h200, 0, 0, 0,      0, 0, 0, 1, 0, 2);

        // Test 1: reset state and init sweep length
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready0, 0);
        chk("rst_pv", pv0, 0);
        chk("rst_pt", pt0, 0);
        chk("rst_ph", ph0, 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        wait_ready("init_cycles");

        // Test 5: gshare index 0x18>>3 ^ 3 = 0 decremented to 1
        apply(mk(1, 0, 0, 0, 1, 'h18, 3, 0, 0, 0, 0, 0));
        apply(idle);
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("gshare_pv", pv1, 1);
        chk("gshare_pt", pt1, 0);
        chk("gshare_ph", ph1, 0);
        chk("gselect_idx0_pt", pt0, 1);

        for (int i = 0; i < 24; i++) begin
            apply(vt[i]);
            chk($sformatf("vec%0d_pv", i), pv0, vt[i].epv);
            chk($sformatf("vec%0d_pt", i), pt0, vt[i].ept);
            chk($sformatf("vec%0d_ph", i), ph0, vt[i].eph);
        end

        // Reset mid-update with a valid taken prediction outstanding
        apply(mk(1, 1, 'h100, 0, 1, 'h200, 2, 0, 0, 0, 0, 0));
        chk("pre_rst_pv", pv0, 1);
        rst = 1'b1;
        #1;
        chk("midupd_ready", ready0, 0);
        chk("midupd_pv", pv0, 0);
        chk("midupd_pt", pt0, 0);
        chk("midupd_ph", ph0, 0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0; ip_valid = 1'b0; xisBranch = 1'b0; xmispredict = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("midinit_ready", ready0, 0);
        rst = 1'b1;
        #1;
        chk("midinit_rst_ready", ready0, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("reinit_cycles");

        // Gshare entry 0 was 1 before reset; the sweep restores weakly taken
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("reinit_gshare_pt", pt1, 1);
        chk("reinit_pv", pv0, 1);
        chk("reinit_ph", ph0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
